// File: rtl/scie_cmd_adapter_if.sv
// Command, SCIE issue and response signals of scie_cmd_adapter.
// The adapter connects through the slave modport; its environment uses master.
interface scie_cmd_adapter_if #(
  parameter int XLEN = 32
);
  logic            io_cmd_valid;
  logic            io_cmd_ready;
  logic [31:0]     io_cmd_insn;
  logic [XLEN-1:0] io_cmd_rs1;
  logic [XLEN-1:0] io_cmd_rs2;
  logic            io_scie_valid;
  logic [31:0]     io_scie_insn;
  logic [XLEN-1:0] io_scie_rs1;
  logic [XLEN-1:0] io_scie_rs2;
  logic [XLEN-1:0] io_scie_rd;
  logic            io_resp_valid;
  logic            io_resp_ready;
  logic [XLEN-1:0] io_resp_data;
  logic [4:0]      io_resp_rd;
  logic            io_busy;

  modport slave (
    input  io_cmd_valid, io_cmd_insn, io_cmd_rs1, io_cmd_rs2, io_scie_rd, io_resp_ready,
    output io_cmd_ready, io_scie_valid, io_scie_insn, io_scie_rs1, io_scie_rs2,
           io_resp_valid, io_resp_data, io_resp_rd, io_busy
  );

  modport master (
    output io_cmd_valid, io_cmd_insn, io_cmd_rs1, io_cmd_rs2, io_scie_rd, io_resp_ready,
    input  io_cmd_ready, io_scie_valid, io_scie_insn, io_scie_rs1, io_scie_rs2,
           io_resp_valid, io_resp_data, io_resp_rd, io_busy
  );
endinterface

// File: rtl/scie_cmd_adapter.sv
// Queues core commands, issues them in order to a fixed-latency SCIE unit and returns results in order.
// Define SCIE_CMD_BYPASS_EN to let a command arriving at an empty queue issue in its accept cycle.
module scie_cmd_adapter #(
  parameter int         XLEN         = 32,
  parameter int         CMD_DEPTH    = 4,
  parameter int         RESP_DEPTH   = 2,
  parameter int         SCIE_LATENCY = 1,
  parameter logic [6:0] RESP_OPCODE  = 7'h5B
) (
  input  logic              clock,
  input  logic              reset,
  scie_cmd_adapter_if.slave io
);
  localparam int CAW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int RAW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RESP_DEPTH) + 1;

  logic [31:0]     r_cmd_insn [CMD_DEPTH];
  logic [XLEN-1:0] r_cmd_rs1  [CMD_DEPTH];
  logic [XLEN-1:0] r_cmd_rs2  [CMD_DEPTH];
  logic [CAW-1:0]  r_cmd_wp, r_cmd_rp;
  logic [CCW-1:0]  r_cmd_cnt;

  logic [XLEN-1:0] r_resp_data [RESP_DEPTH];
  logic [4:0]      r_resp_idx  [RESP_DEPTH];
  logic [RAW-1:0]  r_resp_wp, r_resp_rp;
  logic [RCW-1:0]  r_resp_cnt;

  // One slot per SCIE pipeline stage; only result-producing commands set the valid bit.
  logic [SCIE_LATENCY-1:0]      r_pipe_v;
  logic [SCIE_LATENCY-1:0][4:0] r_pipe_rd;

  logic            w_cmd_empty, w_cmd_full, w_bypass;
  logic [31:0]     w_head_insn;
  logic [XLEN-1:0] w_head_rs1, w_head_rs2;
  logic            w_head_avail, w_head_resp, w_credit_ok, w_issue;
  logic            w_cmd_enq, w_cmd_deq, w_capture, w_resp_deq, w_resp_valid;

  function automatic logic [CAW-1:0] cmd_next(input logic [CAW-1:0] p);
    return (p == CAW'(CMD_DEPTH - 1)) ? '0 : p + CAW'(1);
  endfunction

  function automatic logic [RAW-1:0] resp_next(input logic [RAW-1:0] p);
    return (p == RAW'(RESP_DEPTH - 1)) ? '0 : p + RAW'(1);
  endfunction

  always_comb begin
    w_cmd_empty = (r_cmd_cnt == '0);
    w_cmd_full  = (r_cmd_cnt == CCW'(CMD_DEPTH));
`ifdef SCIE_CMD_BYPASS_EN
    w_bypass    = w_cmd_empty & io.io_cmd_valid;
`else
    w_bypass    = 1'b0;
`endif
    w_head_insn  = w_bypass ? io.io_cmd_insn : r_cmd_insn[r_cmd_rp];
    w_head_rs1   = w_bypass ? io.io_cmd_rs1  : r_cmd_rs1[r_cmd_rp];
    w_head_rs2   = w_bypass ? io.io_cmd_rs2  : r_cmd_rs2[r_cmd_rp];
    w_head_avail = ~w_cmd_empty | w_bypass;
    w_head_resp  = (w_head_insn[6:0] == RESP_OPCODE);
    // Credit uses the registered count, so a response leaving this cycle frees its slot next cycle.
    w_credit_ok  = ($countones(r_pipe_v) + int'(r_resp_cnt)) < RESP_DEPTH;
    w_issue      = w_head_avail & (~w_head_resp | w_credit_ok);
    w_cmd_enq    = io.io_cmd_valid & ~w_cmd_full & ~(w_bypass & w_issue);
    w_cmd_deq    = w_issue & ~w_cmd_empty;
    w_capture    = r_pipe_v[SCIE_LATENCY-1];
    w_resp_valid = (r_resp_cnt != '0);
    w_resp_deq   = w_resp_valid & io.io_resp_ready;

    io.io_cmd_ready  = ~w_cmd_full;
    io.io_scie_valid = w_issue;
    io.io_scie_insn  = w_issue ? w_head_insn : '0;
    io.io_scie_rs1   = w_issue ? w_head_rs1  : '0;
    io.io_scie_rs2   = w_issue ? w_head_rs2  : '0;
    io.io_resp_valid = w_resp_valid;
    io.io_resp_data  = w_resp_valid ? r_resp_data[r_resp_rp] : '0;
    io.io_resp_rd    = w_resp_valid ? r_resp_idx[r_resp_rp]  : '0;
    io.io_busy       = ~w_cmd_empty | (|r_pipe_v) | w_resp_valid;
  end

  always_ff @(posedge clock) begin
    if (w_cmd_enq) begin
      r_cmd_insn[r_cmd_wp] <= io.io_cmd_insn;
      r_cmd_rs1[r_cmd_wp]  <= io.io_cmd_rs1;
      r_cmd_rs2[r_cmd_wp]  <= io.io_cmd_rs2;
    end
    if (w_capture) begin
      r_resp_data[r_resp_wp] <= io.io_scie_rd;
      r_resp_idx[r_resp_wp]  <= r_pipe_rd[SCIE_LATENCY-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmd_wp   <= '0;
      r_cmd_rp   <= '0;
      r_cmd_cnt  <= '0;
      r_resp_wp  <= '0;
      r_resp_rp  <= '0;
      r_resp_cnt <= '0;
      r_pipe_v   <= '0;
      r_pipe_rd  <= '0;
    end else begin
      if (w_cmd_enq) r_cmd_wp <= cmd_next(r_cmd_wp);
      if (w_cmd_deq) r_cmd_rp <= cmd_next(r_cmd_rp);
      r_cmd_cnt  <= r_cmd_cnt + CCW'(w_cmd_enq) - CCW'(w_cmd_deq);
      r_pipe_v   <= SCIE_LATENCY'({r_pipe_v, w_issue & w_head_resp});
      r_pipe_rd  <= (SCIE_LATENCY * 5)'({r_pipe_rd, w_head_insn[11:7]});
      if (w_capture)  r_resp_wp <= resp_next(r_resp_wp);
      if (w_resp_deq) r_resp_rp <= resp_next(r_resp_rp);
      r_resp_cnt <= r_resp_cnt + RCW'(w_capture) - RCW'(w_resp_deq);
    end
  end
endmodule
